// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN evaluator: opcodes, error codes and FSM states.
package rpn_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_UNDER = 3'd1;
  localparam logic [2:0] ERR_OVER  = 3'd2;
  localparam logic [2:0] ERR_DEPTH = 3'd3;
  localparam logic [2:0] ERR_OPC   = 3'd4;

  typedef enum logic [3:0] {
    FETCH,
    PUSH_OPD,
    POP_B,
    POP_A,
    PUSH_RES,
    CHECK,
    POP_RES,
    DRAIN,
    SKIP
  } state_t;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic/logic unit for the RPN evaluator; wrap-around results.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    opcode,
  output logic [DW-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// Reverse-Polish evaluator: turns a token stream into push/pop commands on an
// external LIFO and reports one result or one error per expression.
module rpn_eval
  import rpn_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_is_op,
  input  logic [DW-1:0] tok_data,
  input  logic          tok_last,
  output logic          stk_push,
  output logic [DW-1:0] stk_data,
  output logic          stk_pop,
  input  logic [DW-1:0] stk_top,
  input  logic          stk_ready,
  input  logic          stk_valid,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          err_valid,
  output logic [2:0]    err_code
);

  localparam int CW = $clog2(STACK_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] depth, depth_nxt;
  logic [DW-1:0] b_q, alu_y, data_nxt;
  logic [2:0]    opc_q, code_nxt;
  logic          last_q, hs;
  logic          push_nxt, pop_nxt, ready_nxt, err_nxt, res_nxt;

  // Operand a is taken straight from the stack top during POP_A, so the
  // result is registered into stk_data on the same edge that captures a.
  rpn_alu #(.DW(DW)) u_alu (
    .a      (stk_top),
    .b      (b_q),
    .opcode (opc_q),
    .result (alu_y)
  );

  always_comb begin
    hs        = tok_valid && tok_ready;
    depth_nxt = depth + CW'(stk_push) - CW'(stk_pop);
    state_nxt = state;
    data_nxt  = stk_data;
    code_nxt  = err_code;
    err_nxt   = 1'b0;
    res_nxt   = 1'b0;

    case (state)
      FETCH: begin
        if (hs) begin
          if (!tok_is_op) begin
            if (depth == FULL || !stk_ready) begin
              err_nxt   = 1'b1;
              code_nxt  = ERR_OVER;
              state_nxt = DRAIN;
            end else begin
              data_nxt  = tok_data;
              state_nxt = PUSH_OPD;
            end
          end else if (depth < CW'(2) || !stk_valid) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_UNDER;
            state_nxt = DRAIN;
          end else if (tok_data[2:0] > OP_XOR) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_OPC;
            state_nxt = DRAIN;
          end else begin
            state_nxt = POP_B;
          end
        end
      end
      PUSH_OPD, PUSH_RES: state_nxt = last_q ? CHECK : FETCH;
      POP_B:   state_nxt = POP_A;
      POP_A: begin
        data_nxt  = alu_y;
        state_nxt = PUSH_RES;
      end
      CHECK: begin
        if (depth == CW'(1)) begin
          state_nxt = POP_RES;
        end else begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_DEPTH;
          state_nxt = DRAIN;
        end
      end
      POP_RES: begin
        res_nxt   = 1'b1;
        state_nxt = FETCH;
      end
      DRAIN: begin
        if (depth_nxt == '0) state_nxt = last_q ? FETCH : SKIP;
      end
      SKIP: begin
        if (hs && tok_last) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    // Commands are decoded from the next state so they leave a flop cleanly.
    push_nxt  = (state_nxt == PUSH_OPD) || (state_nxt == PUSH_RES);
    pop_nxt   = (state_nxt == POP_B) || (state_nxt == POP_A) ||
                (state_nxt == POP_RES) ||
                ((state_nxt == DRAIN) && (depth_nxt != '0));
    ready_nxt = (state_nxt == FETCH) || (state_nxt == SKIP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      depth     <= '0;
      b_q       <= '0;
      opc_q     <= '0;
      last_q    <= 1'b0;
      tok_ready <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_data  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      tok_ready <= ready_nxt;
      stk_push  <= push_nxt;
      stk_pop   <= pop_nxt;
      stk_data  <= data_nxt;
      res_valid <= res_nxt;
      err_valid <= err_nxt;
      err_code  <= code_nxt;
      if (state == FETCH && hs) begin
        last_q <= tok_last;
        opc_q  <= tok_data[2:0];
      end
      if (state == POP_B) b_q <= stk_top;
      if (res_nxt) res_data <= stk_top;
    end
  end

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval: behavioural LIFO beside the DUT, queue-based RPN model,
// directed scenarios followed by randomized expressions.
module tb_rpn_eval;

  localparam int SD = 4;

  typedef struct {
    bit          is_op;
    logic [31:0] data;
  } tok_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tok_valid, tok_ready, tok_is_op, tok_last;
  logic [31:0] tok_data;
  logic        stk_push, stk_pop, stk_ready, stk_valid;
  logic [31:0] stk_data, stk_top;
  logic        res_valid, err_valid;
  logic [31:0] res_data;
  logic [2:0]  err_code;

  int passed = 0;
  int total  = 0;
  int proto_err = 0;
  int sp = 0;
  logic [31:0] mem [SD];

  tok_t        expr_q[$];
  logic [31:0] exp_push[$];
  logic [31:0] push_log[$];
  logic [31:0] res_q[$];
  logic [2:0]  err_q[$];
  time         last_hs_time, res_time;
  bit          last_hs_op;

  rpn_eval #(.STACK_DEPTH(SD), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .tok_last  (tok_last),
    .stk_push  (stk_push),
    .stk_data  (stk_data),
    .stk_pop   (stk_pop),
    .stk_top   (stk_top),
    .stk_ready (stk_ready),
    .stk_valid (stk_valid),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Attached stack: combinational top, shares the synchronous reset.
  assign stk_top   = (sp > 0) ? mem[sp-1] : 32'd0;
  assign stk_ready = (sp < SD);
  assign stk_valid = (sp > 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      sp <= 0;
    end else begin
      if (stk_push && stk_pop) proto_err <= proto_err + 1;
      if (stk_push) begin
        if (sp < SD) begin
          mem[sp] <= stk_data;
          sp      <= sp + 1;
        end else begin
          proto_err <= proto_err + 1;
        end
      end else if (stk_pop) begin
        if (sp > 0) sp <= sp - 1;
        else proto_err <= proto_err + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (stk_push) push_log.push_back(stk_data);
      if (res_valid) begin
        res_q.push_back(res_data);
        res_time = $time;
      end
      if (err_valid) err_q.push_back(err_code);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      passed++;
  endtask

  task automatic addTok(input bit is_op, input logic [31:0] data);
    tok_t t;
    t.is_op = is_op;
    t.data  = data;
    expr_q.push_back(t);
  endtask

  // Reference: evaluate the whole expression on a queue, stopping at the first error.
  function automatic void modelEval(output bit is_err, output logic [31:0] val);
    logic [31:0] st[$];
    logic [31:0] a, b, r;
    is_err = 1'b0;
    val    = '0;
    foreach (expr_q[i]) begin
      if (!expr_q[i].is_op) begin
        if (st.size() == SD) begin is_err = 1'b1; val = 32'd2; return; end
        st.push_back(expr_q[i].data);
        exp_push.push_back(expr_q[i].data);
      end else begin
        if (st.size() < 2) begin is_err = 1'b1; val = 32'd1; return; end
        if (expr_q[i].data[2:0] > 3'd5) begin is_err = 1'b1; val = 32'd4; return; end
        b = st.pop_back();
        a = st.pop_back();
        case (expr_q[i].data[2:0])
          3'd0:    r = a + b;
          3'd1:    r = a - b;
          3'd2:    r = a * b;
          3'd3:    r = a & b;
          3'd4:    r = a | b;
          default: r = a ^ b;
        endcase
        st.push_back(r);
        exp_push.push_back(r);
      end
    end
    if (st.size() != 1) begin
      is_err = 1'b1;
      val    = 32'd3;
    end else begin
      val = st[0];
    end
  endfunction

  task automatic applyStimulus(input bit is_op, input logic [31:0] data, input bit last, input int gap);
    int guard;
    tok_valid = 1'b0;
    repeat (gap) @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = data;
    tok_last  = last;
    guard = 0;
    while (!tok_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!tok_ready) begin
      checkOutput("tok_ready_timeout", {31'd0, tok_ready}, 32'd1);
      tok_valid = 1'b0;
      return;
    end
    @(posedge clk);
    last_hs_time = $time;
    last_hs_op   = is_op;
    @(negedge clk);
    tok_valid = 1'b0;
    tok_data  = $urandom;
  endtask

  task automatic runExpr(input string name, input int max_gap);
    bit          exp_err;
    logic [31:0] exp_val;
    int          n;
    res_q.delete();
    err_q.delete();
    push_log.delete();
    exp_push.delete();
    modelEval(exp_err, exp_val);
    for (int i = 0; i < expr_q.size(); i++)
      applyStimulus(expr_q[i].is_op, expr_q[i].data, (i == expr_q.size() - 1), $urandom_range(0, max_gap));
    repeat (20) @(negedge clk);
    checkOutput({name, ":res_count"}, res_q.size(), exp_err ? 32'd0 : 32'd1);
    checkOutput({name, ":err_count"}, err_q.size(), exp_err ? 32'd1 : 32'd0);
    if (exp_err && err_q.size() > 0)
      checkOutput({name, ":err_code"}, {29'd0, err_q[0]}, exp_val);
    if (!exp_err && res_q.size() > 0) begin
      checkOutput({name, ":res_data"}, res_q[0], exp_val);
      checkOutput({name, ":latency"}, 32'(res_time - last_hs_time), last_hs_op ? 32'd55 : 32'd35);
    end
    checkOutput({name, ":push_count"}, push_log.size(), exp_push.size());
    n = (push_log.size() < exp_push.size()) ? push_log.size() : exp_push.size();
    for (int i = 0; i < n; i++)
      checkOutput({name, ":push_data"}, push_log[i], exp_push[i]);
    checkOutput({name, ":stack_empty"}, sp, 32'd0);
    expr_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    tok_valid = 1'b0;
    tok_is_op = 1'b0;
    tok_data  = '0;
    tok_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_flags", {27'd0, stk_push, stk_pop, res_valid, err_valid, tok_ready}, 32'd0);
    checkOutput("reset_res_data", res_data, 32'd0);
    checkOutput("reset_err_code", {29'd0, err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("tok_ready_after_release", {31'd0, tok_ready}, 32'd1);

    // 3 4 + 5 *  -> 35
    addTok(0, 32'd3); addTok(0, 32'd4); addTok(1, 32'd0); addTok(0, 32'd5); addTok(1, 32'd2);
    runExpr("mul_chain", 0);

    addTok(0, 32'd10); addTok(0, 32'd3); addTok(1, 32'd1);
    runExpr("sub", 0);
    addTok(0, 32'd2); addTok(0, 32'd2); addTok(1, 32'd5);
    runExpr("xor_zero", 0);

    addTok(0, 32'd7); addTok(1, 32'd0); addTok(0, 32'd9);
    runExpr("underflow_skip", 1);

    for (int v = 1; v <= 5; v++) addTok(0, 32'(v));
    runExpr("overflow", 0);

    addTok(0, 32'd1); addTok(0, 32'd2);
    runExpr("bad_depth", 0);
    addTok(0, 32'd6);
    runExpr("single", 0);

    addTok(0, 32'd1); addTok(0, 32'd1); addTok(1, 32'd6);
    runExpr("bad_opcode", 0);

    // Reset while the multiply is in POP_A.
    applyStimulus(0, 32'd8, 0, 0);
    applyStimulus(0, 32'd2, 0, 0);
    applyStimulus(1, 32'd2, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midreset_cmds", {29'd0, stk_push, stk_pop, tok_ready}, 32'd0);
    checkOutput("midreset_stack", sp, 32'd0);
    addTok(0, 32'd4);
    runExpr("after_reset", 0);

    for (int n = 0; n < 30; n++) begin
      int cnt;
      int len;
      bit is_op;
      logic [31:0] d;
      cnt = 0;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        is_op = (cnt >= 2) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        if (is_op) begin
          d      = $urandom;
          d[2:0] = 3'($urandom_range(0, 6));
          cnt--;
        end else begin
          d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 50));
          cnt++;
        end
        addTok(is_op, d);
      end
      runExpr("rand", 3);
    end

    checkOutput("protocol_violations", proto_err, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rpn_eval.md
Name: rpn_eval

Overview:
Upstream controller that drives a 32-bit LIFO stack to evaluate Reverse-Polish expressions. It accepts a token stream over a valid/ready handshake and turns each token into push/pop commands on the stack's push/data_in/pop/data_out/ready/valid interface. It emits one result, or one error, per expression. The stack itself is instantiated beside this block at the same level.

Parameters:
STACK_DEPTH, 8, capacity of the attached stack; must equal that stack's SIZE.
DW, 32, token and stack data width.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
tok_valid  input  1  token present
tok_ready  output  1  block accepts a token this cycle
tok_is_op  input  1  1 = operator, 0 = operand
tok_data  input  DW  operand value, or opcode in bits [2:0]
tok_last  input  1  final token of the expression
stk_push  output  1  push command to the stack
stk_data  output  DW  push data
stk_pop  output  1  pop command to the stack
stk_top  input  DW  stack top-of-stack data (combinational)
stk_ready  input  1  stack not full
stk_valid  input  1  stack not empty
res_valid  output  1  one-cycle pulse: result_data is valid
res_data  output  DW  expression result, held until the next result
err_valid  output  1  one-cycle pulse: expression aborted
err_code  output  3  error code, held until the next error

Behaviour:
- Reset: one clock, synchronous and active-low. Reset is sampled only on the rising edge of clk while rst_n=0. On reset: state=FETCH, depth=0, all outputs 0 (tok_ready goes to 1 the cycle after release). The stack shares rst_n. Reset mid-expression discards everything, and no push or pop is issued while rst_n=0.
- depth: internal counter, $clog2(STACK_DEPTH)+1 bits. It mirrors the stack occupancy: +1 on stk_push, -1 on stk_pop.
- Stack commands are registered outputs. stk_push and stk_pop are never both 1 in the same cycle.
- FSM states: FETCH, PUSH_OPD, POP_B, POP_A, PUSH_RES, CHECK, POP_RES, DRAIN, SKIP.
- FETCH: tok_ready=1. A handshake (tok_valid&tok_ready) latches the token and tok_last.
  - Operand: if depth==STACK_DEPTH or !stk_ready, error code 2 (overflow). Otherwise go to PUSH_OPD.
  - Operator: if depth<2, error code 1 (underflow). If opcode>5, error code 4 (bad opcode). Otherwise go to POP_B.
- PUSH_OPD: stk_push=1, stk_data=operand. Then go to CHECK if last, else FETCH.
- POP_B: b<=stk_top, stk_pop=1.
- POP_A: a<=stk_top, stk_pop=1. The stack's combinational top reflects the pop one cycle later, so each capture reads the new top.
- PUSH_RES: stk_push=1, stk_data=alu(a,b). Then go to CHECK if last, else FETCH.
- Opcodes (low DW bits, wrap-around, no saturation): 0 ADD a+b; 1 SUB a-b; 2 MUL low DW bits of a*b; 3 AND; 4 OR; 5 XOR.
- CHECK: if depth==1, go to POP_RES. Otherwise error code 3 (bad final depth).
- POP_RES: res_data<=stk_top, stk_pop=1, res_valid pulse on the next cycle. Then go to FETCH.
- Latency from token handshake to stack write:
  - operand: push in the next cycle (2 cycles/token);
  - operator: 4 cycles/token.
  - Result: res_valid 3 cycles after the last handshake if the last token is an operand; 5 cycles after if it is an operator.
- Error path:
  - err_valid pulses for 1 cycle and err_code is latched. The offending token causes no push or pop.
  - DRAIN: pop while depth!=0.
  - If the offending token was tok_last, go to FETCH. Otherwise go to SKIP.
  - SKIP: tok_ready=1; discard tokens until the tok_last handshake, then go to FETCH.
- tok_valid gaps are allowed in any state. tok_data is only sampled on a handshake.

Decomposition:
- Package rpn_pkg:
  - opcode constants OP_ADD..OP_XOR;
  - ERR_NONE=0, ERR_UNDER=1, ERR_OVER=2, ERR_DEPTH=3, ERR_OPC=4;
  - state enum.
- Sub-module rpn_alu: combinational (a, b, opcode) -> DW result.
- The FSM and depth counter stay in rpn_eval.

Test Plan:
- Tokens 3, 4, +, 5, *(last) -> stk_push data 3, 4, 7, 5, 35; res_data=35 with one res_valid pulse; depth=0 afterwards.
- Tokens 10, 3, -(last), then 2, 2, ^(last, XOR) back-to-back -> res 7, then res 0; no err_valid.
- Tokens 7, +, 9(last) -> err_code=1 at the "+" handshake; one pop drains 7; 9 is discarded in SKIP; no res_valid; stack empty.
- STACK_DEPTH=4, operands 1..5 -> err_code=2 on the 5th operand; 4 pops in DRAIN; stk_push never asserted with stk_ready=0.
- Tokens 1, 2(last) -> err_code=3; 2 pops; the next expression 6(last) gives res 6.
- rst_n=0 for 1 cycle during POP_A of "8 2 *", then 4(last) -> no stale pop/push after reset; res 4.
